// File: rtl/reg_file_8x8_pkg.sv
// Shared sizing constants and word/address types for the 8x8 register file.
package reg_file_8x8_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_word_t;

endpackage

// File: rtl/reg_file_wdec.sv
// One-hot write-enable decoder: selects the register addressed by wa when we is high.
module reg_file_wdec #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic [ADDR_W-1:0]      wa,
    input  logic                   we,
    output logic [2**ADDR_W-1:0]   sel
);

    always_comb begin
        sel = '0;
        if (we) begin
            sel[wa] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_8x8.sv
// Eight-entry register file: two combinational read ports, one synchronous write port.
module reg_file_8x8
    import reg_file_8x8_pkg::*;
#(
    parameter int unsigned DATA_W = reg_file_8x8_pkg::DATA_W,
    parameter int unsigned ADDR_W = reg_file_8x8_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] wa,
    input  logic              we,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   wsel;

    reg_file_wdec #(
        .ADDR_W (ADDR_W)
    ) u_wdec (
        .wa  (wa),
        .we  (we),
        .sel (wsel)
    );

    // Reset takes priority over any pending write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (wsel[i]) begin
                    regs[i] <= wd;
                end
            end
        end
    end

    // No write bypass: reads see the stored value until the edge.
    assign rd_a = regs[ra];
    assign rd_b = regs[rb];

endmodule

// File: tb/tb_reg_file_8x8.sv
// Directed bench for reg_file_8x8: vector table plus hand-written reset/collision sequences.
module tb_reg_file_8x8;

    logic       clk;
    logic       rst;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] wa;
    logic       we;
    logic [7:0] wd;
    logic [7:0] rd_a;
    logic [7:0] rd_b;

    int total;
    int bad;

    typedef struct {
        logic       rst;
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs [9];

    reg_file_8x8 #(
        .DATA_W (8),
        .ADDR_W (3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .ra   (ra),
        .rb   (rb),
        .wa   (wa),
        .we   (we),
        .wd   (wd),
        .rd_a (rd_a),
        .rd_b (rd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [2:0] a,
                                input logic [7:0] d, input logic [2:0] x, input logic [2:0] y,
                                input logic [7:0] ea, input logic [7:0] eb);
        vec_t v;
        v.rst = r; v.we = w; v.wa = a; v.wd = d;
        v.ra = x; v.rb = y; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    initial begin
        logic [7:0] pat;
        total = 0;
        bad   = 0;
        rst = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;

        // Expected values are read after the edge that applies each row.
        vecs[0] = mk(1, 0, 3'd0, 8'h00, 3'd0, 3'd7, 8'h00, 8'h00);
        vecs[1] = mk(0, 1, 3'd3, 8'h55, 3'd3, 3'd0, 8'h55, 8'h00);
        vecs[2] = mk(0, 1, 3'd1, 8'hA5, 3'd3, 3'd1, 8'h55, 8'hA5);
        vecs[3] = mk(0, 1, 3'd6, 8'h3C, 3'd1, 3'd6, 8'hA5, 8'h3C);
        vecs[4] = mk(0, 0, 3'd6, 8'hEE, 3'd6, 3'd1, 8'h3C, 8'hA5);
        vecs[5] = mk(0, 0, 3'd2, 8'hFF, 3'd2, 3'd3, 8'h00, 8'h55);
        vecs[6] = mk(0, 0, 3'd2, 8'hFF, 3'd2, 3'd6, 8'h00, 8'h3C);
        vecs[7] = mk(0, 1, 3'd4, 8'h11, 3'd4, 3'd2, 8'h11, 8'h00);
        vecs[8] = mk(0, 0, 3'd4, 8'h22, 3'd4, 3'd4, 8'h11, 8'h11);

        #2;
        for (int i = 0; i < 9; i++) begin
            rst = vecs[i].rst; we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            ra = vecs[i].ra; rb = vecs[i].rb;
            step();
            check($sformatf("vec%0d_a", i), rd_a, vecs[i].exp_a);
            check($sformatf("vec%0d_b", i), rd_b, vecs[i].exp_b);
        end

        // Combinational read: address change alone updates outputs.
        we = 1'b0; ra = 3'd1; rb = 3'd3;
        #1;
        check("comb_read_a", rd_a, 8'hA5);
        check("comb_read_b", rd_b, 8'h55);

        // Read-during-write on R4: old value before the edge, new value after.
        ra = 3'd4; rb = 3'd4; we = 1'b1; wa = 3'd4; wd = 8'h22;
        #1;
        check("rdw_before_a", rd_a, 8'h11);
        check("rdw_before_b", rd_b, 8'h11);
        step();
        we = 1'b0;
        #1;
        check("rdw_after_a", rd_a, 8'h22);
        check("rdw_after_b", rd_b, 8'h22);

        // Reset/write collision on R5 (pre-loaded so a dropped reset is visible).
        we = 1'b1; wa = 3'd5; wd = 8'h99;
        step();
        ra = 3'd5;
        #1;
        check("r5_preload", rd_a, 8'h99);
        rst = 1'b1; we = 1'b1; wa = 3'd5; wd = 8'h77;
        step();
        check("collision_r5", rd_a, 8'h00);

        // Releasing reset with we held: first non-reset edge writes.
        rst = 1'b0; we = 1'b1; wa = 3'd5; wd = 8'h77;
        step();
        we = 1'b0;
        #1;
        check("rst_release_write", rd_a, 8'h77);

        // Fill all eight with distinct values, including R0.
        for (int i = 0; i < 8; i++) begin
            pat = 8'(i * 19 + 7);
            we = 1'b1; wa = 3'(i); wd = pat;
            step();
        end
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pat = 8'(i * 19 + 7);
            ra = 3'(i); rb = 3'(7 - i);
            #1;
            check($sformatf("fill_a_r%0d", i), rd_a, pat);
            check($sformatf("fill_b_r%0d", 7 - i), rd_b, 8'((7 - i) * 19 + 7));
        end

        // Two-cycle reset pulse clears every register.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            ra = 3'(i); rb = 3'(i);
            #1;
            check($sformatf("clr_a_r%0d", i), rd_a, 8'h00);
            check($sformatf("clr_b_r%0d", i), rd_b, 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
